ascii2key_tx: RTL
=================

# ascii2key_tx

Keyboard-side scan-code sequencer: takes one ASCII character per handshake and emits the PS/2 Set-2 byte sequence a keyboard would send for one keystroke, a make code followed by F0 and the break code. It is the inverse of the scan-code-to-ASCII decoder in the keyboard path. It drives loopback tests of that decoder and feeds a PS/2 device-side serializer.

## Interface
- No parameters.
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- ascii_in  in  8  character to encode; sampled on accept
- ascii_valid  in  1  upstream has a character
- ascii_ready  out  1  block can accept; high only in IDLE and not in reset
- code_out  out  8  current scan-code byte
- code_valid  out  1  code_out is valid
- code_ready  in  1  downstream takes code_out this cycle
- busy  out  1  high in any state except IDLE
- unmapped  out  1  one-cycle pulse: the accepted character has no scan code

## Operation
- Accept: ascii_valid && ascii_ready at a rising edge. On accept, the lookup result is registered into a code register.
- Lookup is the inverse of the decoder table:
  - digits 0x30–0x39 → 45,16,1E,26,25,2E,36,3D,3E,46
  - A–Z 0x41–0x5A → 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A
  - ` → 0E, - → 4E, = → 55, [ → 54, ] → 5B, \ → 5D, ; → 4C, ' → 52, , → 41, . → 49, / → 4A
  - space 0x20 → 29, CR 0x0D → 5A, BS 0x08 → 66
- Lowercase a–z (0x61–0x7A) case-folds to the uppercase code. The exception is under the configuration macro (see Configuration).
- Everything else is unmapped, including 0x2A and 0x7B. On an unmapped character, unmapped pulses in the cycle after accept, no byte is emitted, and the state stays IDLE.
- States: IDLE → MAKE → BRK_PFX → BRK → IDLE. Each non-IDLE state drives code_valid=1, with code_out = code, F0, code respectively.
- A state advances only on code_valid && code_ready.
- code_out and code_valid hold stable while code_ready is low. There is no timeout.
- ascii_in is ignored while busy.

## Timing
- Reset values: state IDLE; code_valid 0; code_out 00; busy 0; unmapped 0; ascii_ready 0 during reset, 1 in the first cycle after reset deasserts.
- Accept at edge N:
  - Mapped character: MAKE byte is valid in cycle N+1.
  - Unmapped character: unmapped=1 in cycle N+1, and ascii_ready=1 in cycle N+1.
- With code_ready tied high, the three bytes appear in cycles N+1, N+2 and N+3, and ascii_ready is high in N+4. Throughput is one character per 4 cycles.
- A handshake on the last byte at edge M returns the block to IDLE: ascii_ready=1 in cycle M+1, and a new accept is possible at edge M+1. Nothing is accepted in the same cycle as the final byte.
- Reset mid-sequence: the sequence is abandoned immediately. code_valid drops in the cycle after the reset edge, and no partial break code is completed.

## Configuration
- ASCII2KEY_SHIFT_EN:
  - Defined: uppercase A–Z is wrapped in left shift as 12, code, F0, code, F0, 12 (6 bytes), using extra states SH_MAKE before MAKE, and SH_BRK_PFX, SH_BRK after BRK. Lowercase a–z emits the plain 3-byte sequence.
  - Undefined: no shift states exist, and upper and lower case both emit the 3-byte sequence.
- The accept latency is unchanged in both builds.

## Structure
- Shared package ps2_pkg holds:
  - constants BREAK_PFX = 8'hF0 and LSHIFT_CODE = 8'h12
  - the state enum
- Sub-module ascii2scan_lut: purely combinational, ascii[7:0] → {hit, code[7:0], is_upper}. It is shared with any future host-side encoder.

## Test plan
- ascii_in=0x41 'A', code_ready=1 → bytes 1C, F0, 1C in cycles N+1..N+3; ascii_ready high at N+4.
- ascii_in=0x35 '5', code_ready low for 3 cycles during BRK_PFX → F0 is held stable, and no byte is lost or duplicated.
- ascii_in=0x2A → unmapped pulses once, no code_valid, and ascii_ready is high the next cycle.
- Back-to-back characters 0x0D then 0x20 → 5A, F0, 5A, 29, F0, 29 with exactly one idle cycle between the two sequences.
- Reset asserted while in BRK → code_valid is 0 in the next cycle; after release, ascii_ready=1 and a new character 0x08 yields 66, F0, 66.
- With ASCII2KEY_SHIFT_EN defined:
  - 0x5A 'Z' → 12, 1A, F0, 1A, F0, 12.
  - 0x7A 'z' → 1A, F0, 1A.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 scan-code constants and the keystroke sequencer state type.
package ps2_pkg;
  localparam logic [7:0] BREAK_PFX = 8'hF0;
  localparam logic [7:0] LSHIFT_CODE = 8'h12;
  typedef enum logic [2:0] {
    IDLE,
    MAKE,
    BRK_PFX,
    BRK
`ifdef ASCII2KEY_SHIFT_EN
    , SH_MAKE,
    SH_BRK_PFX,
    SH_BRK
`endif
  } state_t;
endpackage

// File: rtl/ascii2scan_lut.sv
// ascii2scan_lut: combinational ASCII to PS/2 Set-2 make code, lowercase folded onto uppercase.
module ascii2scan_lut (
  input  logic [7:0] ascii,
  output logic       hit,
  output logic [7:0] code,
  output logic       is_upper
);
  logic [7:0] c;
  always_comb begin
    c = (ascii >= 8'h61 && ascii <= 8'h7A) ? ascii - 8'h20 : ascii;
    is_upper = ascii >= 8'h41 && ascii <= 8'h5A;
    hit = 1'b1;
    code = 8'h00;
    case (c)
      8'h30: code = 8'h45;
      8'h31: code = 8'h16;
      8'h32: code = 8'h1E;
      8'h33: code = 8'h26;
      8'h34: code = 8'h25;
      8'h35: code = 8'h2E;
      8'h36: code = 8'h36;
      8'h37: code = 8'h3D;
      8'h38: code = 8'h3E;
      8'h39: code = 8'h46;
      8'h41: code = 8'h1C;
      8'h42: code = 8'h32;
      8'h43: code = 8'h21;
      8'h44: code = 8'h23;
      8'h45: code = 8'h24;
      8'h46: code = 8'h2B;
      8'h47: code = 8'h34;
      8'h48: code = 8'h33;
      8'h49: code = 8'h43;
      8'h4A: code = 8'h3B;
      8'h4B: code = 8'h42;
      8'h4C: code = 8'h4B;
      8'h4D: code = 8'h3A;
      8'h4E: code = 8'h31;
      8'h4F: code = 8'h44;
      8'h50: code = 8'h4D;
      8'h51: code = 8'h15;
      8'h52: code = 8'h2D;
      8'h53: code = 8'h1B;
      8'h54: code = 8'h2C;
      8'h55: code = 8'h3C;
      8'h56: code = 8'h2A;
      8'h57: code = 8'h1D;
      8'h58: code = 8'h22;
      8'h59: code = 8'h35;
      8'h5A: code = 8'h1A;
      8'h60: code = 8'h0E;
      8'h2D: code = 8'h4E;
      8'h3D: code = 8'h55;
      8'h5B: code = 8'h54;
      8'h5D: code = 8'h5B;
      8'h5C: code = 8'h5D;
      8'h3B: code = 8'h4C;
      8'h27: code = 8'h52;
      8'h2C: code = 8'h41;
      8'h2E: code = 8'h49;
      8'h2F: code = 8'h4A;
      8'h20: code = 8'h29;
      8'h0D: code = 8'h5A;
      8'h08: code = 8'h66;
      default: hit = 1'b0;
    endcase
  end
endmodule

// File: rtl/ascii2key_tx.sv
// ascii2key_tx: one ASCII char per handshake -> make, F0, break scan-code bytes.
// ASCII2KEY_SHIFT_EN wraps uppercase letters in left-shift make/break.
module ascii2key_tx
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic [7:0] code_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       busy,
  output logic       unmapped
);
  state_t state, state_nx;
  logic [7:0] code, lut_code;
  logic hit, lut_upper, accept;
`ifdef ASCII2KEY_SHIFT_EN
  logic upper;
`else
  logic unused_upper;
  assign unused_upper = lut_upper;
`endif
  ascii2scan_lut u_lut (.ascii(ascii_in), .hit(hit), .code(lut_code), .is_upper(lut_upper));
  assign ascii_ready = state == IDLE && !reset;
  assign busy = state != IDLE;
  assign code_valid = state != IDLE;
  assign accept = ascii_valid && ascii_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      code <= 8'h00;
      unmapped <= 1'b0;
`ifdef ASCII2KEY_SHIFT_EN
      upper <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      unmapped <= accept && !hit;
      if (accept && hit) code <= lut_code;
`ifdef ASCII2KEY_SHIFT_EN
      if (accept && hit) upper <= lut_upper;
`endif
    end
  end
  always_comb begin
    state_nx = state;
    code_out = 8'h00;
    case (state)
`ifdef ASCII2KEY_SHIFT_EN
      IDLE: if (accept && hit) state_nx = lut_upper ? SH_MAKE : MAKE;
      SH_MAKE: begin
        code_out = LSHIFT_CODE;
        if (code_ready) state_nx = MAKE;
      end
      SH_BRK_PFX: begin
        code_out = BREAK_PFX;
        if (code_ready) state_nx = SH_BRK;
      end
      SH_BRK: begin
        code_out = LSHIFT_CODE;
        if (code_ready) state_nx = IDLE;
      end
      BRK: begin
        code_out = code;
        if (code_ready) state_nx = upper ? SH_BRK_PFX : IDLE;
      end
`else
      IDLE: if (accept && hit) state_nx = MAKE;
      BRK: begin
        code_out = code;
        if (code_ready) state_nx = IDLE;
      end
`endif
      MAKE: begin
        code_out = code;
        if (code_ready) state_nx = BRK_PFX;
      end
      BRK_PFX: begin
        code_out = BREAK_PFX;
        if (code_ready) state_nx = BRK;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule
